timer_mmss: RTL and testbench
=============================

Name: timer_mmss

Overview:
- BCD minutes:seconds countdown register for the microwave controller.
- Sits directly downstream of the keypad/timer-control stage and consumes its D, loadn and pgt_1Hz outputs.
- While stopped, keypad digits shift in from the right.
- While running, the value decrements once per 1 Hz tick; zero is flagged to the magnetron/display logic.

Parameters:
- SEC_TENS_MAX, 5, value the seconds-tens digit reloads to on a borrow.
- DIGIT_MAX, 9, value the ones digits and minutes-tens reload to on a borrow.

Ports:
- clk100  input  1  system clock (100 Hz domain); all state changes on its rising edge
- clear  input  1  asynchronous, active-high reset
- D  input  4  BCD digit from the keypad encoder
- loadn  input  1  active-low key-present strobe
- pgt_1Hz  input  1  1 Hz tick (level toggling), sampled on clk100
- enablen  input  1  active-low run request (door closed + start)
- sec_ones  output  4  BCD seconds units
- sec_tens  output  4  BCD seconds tens
- min_ones  output  4  BCD minutes units
- min_tens  output  4  BCD minutes tens
- zero  output  1  high when all four digits are 0
- running  output  1  high in state RUN

Behaviour:
- Clock and reset: single clock clk100; reset clear is asynchronous and active-high.
- Reset values: all digits 0, zero=1, running=0, state IDLE, edge registers loadn_q=1, tick_q=0.
- Edge detection, one-cycle registered:
  - load_ev = loadn_q & ~loadn (falling edge of loadn).
  - tick_ev = ~tick_q & pgt_1Hz (rising edge of pgt_1Hz).
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- IDLE:
  - load_ev with D<=9 → shift left: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←D. Visible next cycle.
  - load_ev with D>9 → ignored.
  - enablen=0 and zero=0 → RUN.
  - enablen=0 and zero=1 → stay IDLE.
  - Ticks ignored.
- RUN:
  - tick_ev decrements by one second:
    - sec_ones 0→DIGIT_MAX with borrow.
    - sec_tens 0→SEC_TENS_MAX with borrow.
    - min_ones 0→DIGIT_MAX with borrow.
    - min_tens decrements; it is never 0 when a borrow reaches it, because RUN exits at zero.
  - A result of 00:00 → DONE in the same cycle the digits update.
  - enablen=1 → PAUSE, digits held. If tick_ev and enablen=1 occur in the same cycle, PAUSE wins and no decrement happens.
  - load_ev ignored.
- PAUSE:
  - Digits held; load_ev and tick_ev ignored.
  - enablen=0 → RUN.
  - No timeout.
- DONE:
  - Digits remain 0, zero=1.
  - enablen=1 → IDLE.
  - load_ev ignored until IDLE.
- Non-normalised seconds: loaded values above 59 (e.g. 00:99) count down digit-wise, 99→98…→90→89; normalisation occurs only through borrows.
- Non-BCD digits: unreachable because D>9 is rejected.
- Outputs:
  - zero is the combinational NOR of the digit registers.
  - running is decoded from state.
- clear mid-RUN: immediate return to reset values.

Optional Feature:
- Macro: TIMER_DONE_PULSE_EN.
- Defined: extra output done_pulse (1 bit) is high for exactly one clk100 cycle on the RUN→DONE transition. Reset value 0.
- Undefined: no done_pulse port and no associated logic. All other behaviour is identical.

Decomposition:
- Package timer_pkg holds:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_DONE=3;
  - BCD constants DIGIT_MAX=9 and SEC_TENS_MAX=5.
- Sub-module bcd_digit_down:
  - parameter MAX;
  - inputs clk100, clear, dec, load, din[3:0];
  - outputs q[3:0] and borrow (asserted when dec and q==0).
- Four instances are chained through borrow; the top level holds the FSM and edge detectors.

Test Plan:
- Reset then key digits 1,3,0 (loadn pulses, D=1,3,0) → display 01:30, zero=0, running=0.
- From 01:30, enablen=0, apply 1 tick → 01:29. After 30 further ticks → 00:59 (borrow through min_ones and sec_tens).
- Load 00:02, run, 2 ticks → 00:00, zero=1, state DONE, running=0. Also with TIMER_DONE_PULSE_EN → done_pulse high for exactly one cycle.
- Load 00:10, run, set enablen=1 before the next tick, apply 3 ticks and a loadn pulse with D=7 → holds 00:10. enablen=0 plus 1 tick → 00:09.
- Load 10:00, run, 1 tick → 09:59. Assert clear mid-count → 00:00, zero=1, IDLE, asynchronously before the next clk100 edge.
- In IDLE, apply loadn pulse with D=12 → no shift. Apply tick and loadn pulse (D=4) in the same cycle in IDLE → shift only, no decrement.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared state encoding and BCD digit limits for the microwave mm:ss countdown timer.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] DIGIT_MAX    = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown: parallel load for keypad shift, decrement with wrap to MAX and borrow-out.
module bcd_digit_down #(
   parameter logic [3:0] MAX = 4'd9
) (
   input  logic       clk100,
   input  logic       clear,
   input  logic       dec,
   input  logic       load,
   input  logic [3:0] din,
   output logic [3:0] q,
   output logic       borrow
);

   assign borrow = dec & (q == 4'd0);

   always_ff @(posedge clk100 or posedge clear) begin
      if (clear)     q <= 4'd0;
      else if (load) q <= din;
      else if (dec)  q <= (q == 4'd0) ? MAX : q - 4'd1;
   end

endmodule

// File: rtl/timer_mmss.sv
// BCD mm:ss countdown register: keypad digits shift in while IDLE, 1 Hz ticks count down while RUN.
// Optional TIMER_DONE_PULSE_EN adds a one-cycle done_pulse on the RUN->DONE transition.
module timer_mmss #(
   parameter logic [3:0] SEC_TENS_MAX = timer_pkg::SEC_TENS_MAX,
   parameter logic [3:0] DIGIT_MAX    = timer_pkg::DIGIT_MAX
) (
   input  logic       clk100,
   input  logic       clear,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       enablen,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       zero,
`ifdef TIMER_DONE_PULSE_EN
   output logic       done_pulse,
`endif
   output logic       running
);

   import timer_pkg::*;

   state_t state, state_nxt;
   logic   loadn_q, tick_q;
   logic   load_ev, tick_ev;
   logic   shift, dec_en, one_left;
   logic   so_b, st_b, mo_b, mt_b;

   always_ff @(posedge clk100 or posedge clear) begin
      if (clear) begin
         loadn_q <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         loadn_q <= loadn;
         tick_q  <= pgt_1Hz;
      end
   end

   assign load_ev = loadn_q & ~loadn;
   assign tick_ev = ~tick_q & pgt_1Hz;

   // Pause request beats a coincident tick, so decrement needs enablen low too.
   assign shift  = (state == ST_IDLE) & load_ev & (D <= 4'd9);
   assign dec_en = (state == ST_RUN) & tick_ev & ~enablen;

   bcd_digit_down #(.MAX(DIGIT_MAX)) u_sec_ones (
      .clk100(clk100), .clear(clear), .dec(dec_en), .load(shift),
      .din(D), .q(sec_ones), .borrow(so_b));

   bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk100(clk100), .clear(clear), .dec(so_b), .load(shift),
      .din(sec_ones), .q(sec_tens), .borrow(st_b));

   bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_ones (
      .clk100(clk100), .clear(clear), .dec(st_b), .load(shift),
      .din(sec_tens), .q(min_ones), .borrow(mo_b));

   bcd_digit_down #(.MAX(DIGIT_MAX)) u_min_tens (
      .clk100(clk100), .clear(clear), .dec(mo_b), .load(shift),
      .din(min_ones), .q(min_tens), .borrow(mt_b));

   assign zero     = ~|{min_tens, min_ones, sec_tens, sec_ones};
   assign running  = (state == ST_RUN);
   assign one_left = (min_tens == 4'd0) & (min_ones == 4'd0) &
                     (sec_tens == 4'd0) & (sec_ones == 4'd1);

   always_ff @(posedge clk100 or posedge clear) begin
      if (clear) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!enablen && !zero) state_nxt = ST_RUN;
         ST_RUN: begin
            if (enablen) state_nxt = ST_PAUSE;
            // mt_b only fires on an underflow RUN should never reach; stop rather than wrap.
            else if (dec_en && (one_left || mt_b)) state_nxt = ST_DONE;
         end
         ST_PAUSE: if (!enablen) state_nxt = ST_RUN;
         ST_DONE:  if (enablen)  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

`ifdef TIMER_DONE_PULSE_EN
   always_ff @(posedge clk100 or posedge clear) begin
      if (clear) done_pulse <= 1'b0;
      else       done_pulse <= (state == ST_RUN) && (state_nxt == ST_DONE);
   end
`endif

endmodule

// File: tb/tb_timer_mmss.sv
// Scenario bench for timer_mmss: expected display words are queued at stimulus time and popped at check time.
module tb_timer_mmss;

   logic       clk100 = 1'b0;
   logic       clear, loadn, pgt_1Hz, enablen;
   logic [3:0] D;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       zero, running;
   logic [17:0] sbq[$];
   logic [17:0] exp_v;
   int          total = 0;
   int          bad = 0;
   int          pcnt = 0;
`ifdef TIMER_DONE_PULSE_EN
   logic        done_pulse;
`endif

   always #5 clk100 = ~clk100;

   timer_mmss dut (
      .clk100(clk100), .clear(clear), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
      .enablen(enablen), .sec_ones(sec_ones), .sec_tens(sec_tens),
      .min_ones(min_ones), .min_tens(min_tens), .zero(zero),
`ifdef TIMER_DONE_PULSE_EN
      .done_pulse(done_pulse),
`endif
      .running(running));

`ifdef TIMER_DONE_PULSE_EN
   always @(negedge clk100) if (done_pulse === 1'b1) pcnt++;
`endif

   wire [17:0] obs = {min_tens, min_ones, sec_tens, sec_ones, zero, running};

   function automatic logic [17:0] mk(input logic [15:0] mmss, input logic z, input logic r);
      return {mmss, z, r};
   endfunction

   task automatic cyc();
      @(posedge clk100); #1;
   endtask

   task automatic key(input logic [3:0] d);
      D = d; loadn = 1'b0; cyc();
      loadn = 1'b1; cyc();
   endtask

   task automatic tick();
      pgt_1Hz = 1'b1; cyc();
      pgt_1Hz = 1'b0; cyc();
   endtask

   task automatic do_clear();
      enablen = 1'b1; loadn = 1'b1; pgt_1Hz = 1'b0; clear = 1'b1;
      cyc();
      clear = 1'b0; cyc();
   endtask

   task automatic test_reset();
      clear = 1'b1; loadn = 1'b1; pgt_1Hz = 1'b0; enablen = 1'b1; D = 4'd0;
      sbq.push_back(mk(16'h0000, 1'b1, 1'b0));
      #3;
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reset: got %h want %h", obs, exp_v); end
      cyc(); clear = 1'b0; cyc();
   endtask

   task automatic test_load();
      key(4'd1); key(4'd3); key(4'd0);
      sbq.push_back(mk(16'h0130, 1'b0, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL load_0130: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_count();
      enablen = 1'b0; cyc();
      tick();
      sbq.push_back(mk(16'h0129, 1'b0, 1'b1));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL tick_0129: got %h want %h", obs, exp_v); end
      repeat (30) tick();
      sbq.push_back(mk(16'h0059, 1'b0, 1'b1));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL borrow_0059: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_done();
      int p0;
      do_clear();
      key(4'd0); key(4'd2);
      enablen = 1'b0; cyc();
      p0 = pcnt;
      tick();
      sbq.push_back(mk(16'h0001, 1'b0, 1'b1));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL done_0001: got %h want %h", obs, exp_v); end
      tick();
      sbq.push_back(mk(16'h0000, 1'b1, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL done_0000: got %h want %h", obs, exp_v); end
      repeat (3) cyc();
`ifdef TIMER_DONE_PULSE_EN
      total++;
      if (pcnt - p0 !== 1) begin bad++; $display("FAIL done_pulse_cycles: got %0d want 1", pcnt - p0); end
`endif
      key(4'd5);
      sbq.push_back(mk(16'h0000, 1'b1, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL done_ignores_key: got %h want %h", obs, exp_v); end
      enablen = 1'b1; cyc();
      key(4'd5);
      sbq.push_back(mk(16'h0005, 1'b0, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL done_to_idle_key: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_pause();
      do_clear();
      key(4'd1); key(4'd0);
      enablen = 1'b0; cyc();
      // pause request and tick edge land in the same cycle
      enablen = 1'b1; pgt_1Hz = 1'b1; cyc();
      pgt_1Hz = 1'b0; cyc();
      repeat (3) tick();
      key(4'd7);
      sbq.push_back(mk(16'h0010, 1'b0, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL pause_hold: got %h want %h", obs, exp_v); end
      enablen = 1'b0; cyc();
      sbq.push_back(mk(16'h0010, 1'b0, 1'b1));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL pause_resume: got %h want %h", obs, exp_v); end
      tick();
      sbq.push_back(mk(16'h0009, 1'b0, 1'b1));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL pause_tick_0009: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_nonnorm();
      do_clear();
      key(4'd9); key(4'd9);
      enablen = 1'b0; cyc();
      tick();
      sbq.push_back(mk(16'h0098, 1'b0, 1'b1));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL nonnorm_0098: got %h want %h", obs, exp_v); end
      repeat (9) tick();
      sbq.push_back(mk(16'h0089, 1'b0, 1'b1));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL nonnorm_0089: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_clear_mid();
      do_clear();
      key(4'd1); key(4'd0); key(4'd0); key(4'd0);
      enablen = 1'b0; cyc();
      tick();
      sbq.push_back(mk(16'h0959, 1'b0, 1'b1));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL tens_borrow_0959: got %h want %h", obs, exp_v); end
      clear = 1'b1;
      sbq.push_back(mk(16'h0000, 1'b1, 1'b0));
      #2;
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL async_clear: got %h want %h", obs, exp_v); end
      enablen = 1'b1; cyc();
      clear = 1'b0; cyc();
      key(4'd3);
      sbq.push_back(mk(16'h0003, 1'b0, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL clear_to_idle: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_idle();
      do_clear();
      enablen = 1'b0; cyc(); cyc();
      sbq.push_back(mk(16'h0000, 1'b1, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL idle_zero_norun: got %h want %h", obs, exp_v); end
      enablen = 1'b1; cyc();
      key(4'd12);
      sbq.push_back(mk(16'h0000, 1'b1, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL reject_d12: got %h want %h", obs, exp_v); end
      D = 4'd4; loadn = 1'b0; pgt_1Hz = 1'b1; cyc();
      loadn = 1'b1; pgt_1Hz = 1'b0; cyc();
      sbq.push_back(mk(16'h0004, 1'b0, 1'b0));
      exp_v = sbq.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL idle_key_tick: got %h want %h", obs, exp_v); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_count();
      test_done();
      test_pause();
      test_nonnorm();
      test_clear_mid();
      test_idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
